// File: rtl/dekatron_pkg.sv
// Shared types and constants for dekatron counter digit stages.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package dekatron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PH_A = 2'd1,
        PH_B = 2'd2
    } state_t;

    // Guide drive encodings as {G1,G2}
    localparam logic [1:0] GUIDE_NONE = 2'b00;
    localparam logic [1:0] GUIDE_G1   = 2'b10;
    localparam logic [1:0] GUIDE_G2   = 2'b01;

    localparam int DEFAULT_RADIX = 10;

endpackage

// File: rtl/dekatron_step_seq_if.sv
// Control/status bundle between a digit controller and one dekatron step sequencer.
// Latency: none; wires only.
// Backpressure: none; Busy/Overrun report step occupancy and lost ticks.
interface dekatron_step_seq_if #(
    parameter int POS_W = 4
);
    logic             tick_in;
    logic             En;
    logic             Dec;
    logic             Load;
    logic [POS_W-1:0] LoadValue;
    logic             ClrOverrun;
    logic [1:0]       Guides;
    logic [POS_W-1:0] Position;
    logic             Carry;
    logic             Busy;
    logic             Overrun;

    modport master (
        output tick_in, En, Dec, Load, LoadValue, ClrOverrun,
        input  Guides, Position, Carry, Busy, Overrun
    );

    modport slave (
        input  tick_in, En, Dec, Load, LoadValue, ClrOverrun,
        output Guides, Position, Carry, Busy, Overrun
    );

endinterface

// File: rtl/tick_edge_detect.sv
// Registered rising-edge detector with enable for a synchronous tick level.
// Latency: o_rise is combinational from i_lvl against last cycle's sample.
// Backpressure: none; a level held high produces only one rise.
module tick_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lvl,
    input  logic i_en,
    output logic o_rise
);

    logic r_q;
    logic r_armed;

    // Sample the level; the first cycle after reset only primes r_q so a
    // tick already high at release is not mistaken for a new edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q     <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_q     <= i_lvl;
            r_armed <= 1'b1;
        end
    end

    assign o_rise = i_lvl & ~r_q & i_en & r_armed;

endmodule

// File: rtl/dekatron_step_seq.sv
// Dekatron guide pulse sequencer: each tick rise runs two guide phases then moves the glow.
// Latency: step occupies 2*PHASE_CYCLES cycles; position/carry visible the cycle after.
// Backpressure: one tick queued while busy; a further tick sets sticky Overrun and is dropped.
module dekatron_step_seq
    import dekatron_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int RADIX        = DEFAULT_RADIX,
    parameter int POS_W        = 4
) (
    input  logic                clock_in,
    input  logic                Rst_n,
    dekatron_step_seq_if.slave  bus
);

    localparam int               CNT_W    = $clog2(PHASE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(RADIX - 1);

    state_t             r_state,  w_state_nxt;
    logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
    logic               r_dir,    w_dir_nxt;
    logic               r_pend,   w_pend_nxt;
    logic [POS_W-1:0]   r_pos,    w_pos_nxt;
    logic               r_carry,  w_carry_nxt;
    logic               r_ovr,    w_ovr_nxt;
    logic [1:0]         w_guides;
    logic               w_rise;
    logic               w_pend_eff;
    logic               w_last;
    logic               w_load_ok;

    tick_edge_detect u_edge (
        .i_clk   (clock_in),
        .i_rst_n (Rst_n),
        .i_lvl   (bus.tick_in),
        .i_en    (bus.En),
        .o_rise  (w_rise)
    );

    // Dropping En discards a queued tick but never aborts the running step.
    assign w_pend_eff = r_pend & bus.En;
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_load_ok  = bus.Load & (bus.LoadValue <= POS_MAX);

    // State and datapath registers
    always_ff @(posedge clock_in or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_pend  <= 1'b0;
            r_pos   <= '0;
            r_carry <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
            r_pend  <= w_pend_nxt;
            r_pos   <= w_pos_nxt;
            r_carry <= w_carry_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    // Next-state, phase timing, position commit and guide drive
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dir_nxt   = r_dir;
        w_pend_nxt  = w_pend_eff;
        w_pos_nxt   = r_pos;
        w_carry_nxt = 1'b0;
        w_ovr_nxt   = r_ovr & ~bus.ClrOverrun;
        w_guides    = GUIDE_NONE;

        case (r_state)
            IDLE: begin
                if (w_load_ok) begin
                    // Load takes priority; a coincident rise waits one cycle
                    w_pos_nxt  = bus.LoadValue;
                    w_pend_nxt = w_pend_eff | w_rise;
                end else if (w_rise | w_pend_eff) begin
                    w_state_nxt = PH_A;
                    w_cnt_nxt   = '0;
                    w_dir_nxt   = bus.Dec;
                    w_pend_nxt  = w_pend_eff & w_rise;
                end
            end

            PH_A, PH_B: begin
                if (r_state == PH_A) begin
                    w_guides = r_dir ? GUIDE_G2 : GUIDE_G1;
                end else begin
                    w_guides = r_dir ? GUIDE_G1 : GUIDE_G2;
                end

                // Queue one tick; a second one while queued is lost
                if (w_rise) begin
                    if (w_pend_eff) begin
                        w_ovr_nxt = 1'b1;
                    end else begin
                        w_pend_nxt = 1'b1;
                    end
                end

                if (!w_last) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (r_state == PH_A) begin
                    w_state_nxt = PH_B;
                    w_cnt_nxt   = '0;
                end else begin
                    // Commit the step, wrapping modulo RADIX
                    if (!r_dir) begin
                        w_pos_nxt   = (r_pos == POS_MAX) ? '0 : r_pos + 1'b1;
                        w_carry_nxt = (r_pos == POS_MAX);
                    end else begin
                        w_pos_nxt   = (r_pos == '0) ? POS_MAX : r_pos - 1'b1;
                        w_carry_nxt = (r_pos == '0);
                    end
                    w_cnt_nxt = '0;
                    if (w_pend_eff | w_rise) begin
                        // Back-to-back step with no idle gap; the queued tick
                        // (or one arriving now) is consumed here
                        w_state_nxt = PH_A;
                        w_dir_nxt   = bus.Dec;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.Guides   = w_guides;
    assign bus.Position = r_pos;
    assign bus.Carry    = r_carry;
    assign bus.Busy     = (r_state != IDLE);
    assign bus.Overrun  = r_ovr;

endmodule

// File: tb/tb_dekatron_step_seq.sv
// Directed bench for the dekatron step sequencer: vector table plus corner-case sequences.
// Latency: checks sample 1 time unit after each rising clock edge.
// Backpressure: exercises queued ticks, overrun and load/tick collisions.
module tb_dekatron_step_seq;
    import dekatron_pkg::*;

    localparam int P = 4;

    logic clock_in = 1'b0;
    logic Rst_n    = 1'b0;

    always #5 clock_in = ~clock_in;

    dekatron_step_seq_if #(.POS_W(4)) bus ();

    dekatron_step_seq #(
        .PHASE_CYCLES (P),
        .RADIX        (10),
        .POS_W        (4)
    ) dut (
        .clock_in (clock_in),
        .Rst_n    (Rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic       ld;
        logic [3:0] lv;
        logic       dec;
        logic [3:0] pos_ld;
        logic [3:0] pos;
        logic       carry;
    } vec_t;

    vec_t vecs [7];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    task automatic pulse();
        bus.tick_in = 1'b1;
        step();
        bus.tick_in = 1'b0;
    endtask

    initial begin
        logic [1:0] g;

        //          ld    lv     dec   pos_ld pos    carry
        vecs[0] = '{1'b0, 4'd0,  1'b0, 4'd0,  4'd1,  1'b0};
        vecs[1] = '{1'b1, 4'd9,  1'b0, 4'd9,  4'd0,  1'b1};
        vecs[2] = '{1'b1, 4'd0,  1'b1, 4'd0,  4'd9,  1'b1};
        vecs[3] = '{1'b0, 4'd0,  1'b1, 4'd9,  4'd8,  1'b0};
        vecs[4] = '{1'b1, 4'd12, 1'b0, 4'd8,  4'd9,  1'b0};
        vecs[5] = '{1'b0, 4'd0,  1'b0, 4'd9,  4'd0,  1'b1};
        vecs[6] = '{1'b1, 4'd5,  1'b1, 4'd5,  4'd4,  1'b0};

        bus.tick_in    = 1'b0;
        bus.En         = 1'b1;
        bus.Dec        = 1'b0;
        bus.Load       = 1'b0;
        bus.LoadValue  = '0;
        bus.ClrOverrun = 1'b0;

        // Reset state
        #12;
        chk("rst_guides",   32'(bus.Guides),   0);
        chk("rst_position", 32'(bus.Position), 0);
        chk("rst_carry",    32'(bus.Carry),    0);
        chk("rst_busy",     32'(bus.Busy),     0);
        chk("rst_overrun",  32'(bus.Overrun),  0);
        Rst_n = 1'b1;
        step();
        step();

        // Table-driven single steps
        for (int k = 0; k < 7; k++) begin
            bus.Dec = vecs[k].dec;
            if (vecs[k].ld) begin
                bus.Load      = 1'b1;
                bus.LoadValue = vecs[k].lv;
                step();
                bus.Load = 1'b0;
            end
            chk($sformatf("v%0d_load_pos", k), 32'(bus.Position), 32'(vecs[k].pos_ld));
            pulse();
            for (int i = 0; i < 2 * P; i++) begin
                if (i < P) g = vecs[k].dec ? GUIDE_G2 : GUIDE_G1;
                else       g = vecs[k].dec ? GUIDE_G1 : GUIDE_G2;
                chk($sformatf("v%0d_guides_%0d", k, i), 32'(bus.Guides), 32'(g));
                chk($sformatf("v%0d_busy_%0d", k, i),   32'(bus.Busy),   1);
                chk($sformatf("v%0d_carry_mid_%0d", k, i), 32'(bus.Carry), 0);
                step();
            end
            chk($sformatf("v%0d_commit_pos", k),    32'(bus.Position), 32'(vecs[k].pos));
            chk($sformatf("v%0d_commit_carry", k),  32'(bus.Carry),    32'(vecs[k].carry));
            chk($sformatf("v%0d_commit_busy", k),   32'(bus.Busy),     0);
            chk($sformatf("v%0d_commit_guides", k), 32'(bus.Guides),   0);
            step();
            chk($sformatf("v%0d_carry_drop", k), 32'(bus.Carry), 0);
        end

        // Pending tick, overrun, set-wins collision; starts from position 4
        bus.Dec = 1'b0;
        pulse();                       // E
        step();
        step();                        // E+2
        pulse();                       // E+3: queued
        chk("pend_no_ovr", 32'(bus.Overrun), 0);
        step();                        // E+4
        pulse();                       // E+5: lost tick
        chk("ovr_set", 32'(bus.Overrun), 1);
        chk("ovr_busy", 32'(bus.Busy), 1);
        step();                        // E+6
        bus.ClrOverrun = 1'b1;
        bus.tick_in    = 1'b1;
        step();                        // E+7: set and clear together
        bus.ClrOverrun = 1'b0;
        bus.tick_in    = 1'b0;
        chk("ovr_set_wins", 32'(bus.Overrun), 1);
        step();                        // E+8: commit, chained step
        chk("chain_pos",    32'(bus.Position), 5);
        chk("chain_guides", 32'(bus.Guides),   32'(GUIDE_G1));
        chk("chain_busy",   32'(bus.Busy),     1);
        chk("chain_carry",  32'(bus.Carry),    0);
        bus.ClrOverrun = 1'b1;
        step();                        // E+9
        bus.ClrOverrun = 1'b0;
        chk("ovr_cleared", 32'(bus.Overrun), 0);
        for (int i = 0; i < 6; i++) step();  // E+15
        chk("chain_busy_last", 32'(bus.Busy), 1);
        step();                        // E+16
        chk("chain2_pos",    32'(bus.Position), 6);
        chk("chain2_busy",   32'(bus.Busy),     0);
        chk("chain2_guides", 32'(bus.Guides),   0);

        // Asynchronous reset in the middle of PH_B
        pulse();
        for (int i = 0; i < P; i++) step();
        chk("phb_before_rst", 32'(bus.Guides), 32'(GUIDE_G2));
        bus.tick_in = 1'b1;
        #2;
        Rst_n = 1'b0;
        #1;
        chk("arst_guides",   32'(bus.Guides),   0);
        chk("arst_position", 32'(bus.Position), 0);
        chk("arst_busy",     32'(bus.Busy),     0);
        chk("arst_carry",    32'(bus.Carry),    0);
        #3;
        Rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("held_tick_busy_%0d", i),   32'(bus.Busy),   0);
            chk($sformatf("held_tick_guides_%0d", i), 32'(bus.Guides), 0);
        end
        bus.tick_in = 1'b0;
        step();

        // En low: ticks ignored
        bus.En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse();
            chk($sformatf("en0_busy_%0d", i), 32'(bus.Busy),     0);
            chk($sformatf("en0_pos_%0d", i),  32'(bus.Position), 0);
            step();
        end
        bus.En = 1'b1;
        step();

        // Load and rise in the same cycle: load first, then one step
        bus.Dec       = 1'b0;
        bus.Load      = 1'b1;
        bus.LoadValue = 4'd5;
        bus.tick_in   = 1'b1;
        step();
        bus.Load    = 1'b0;
        bus.tick_in = 1'b0;
        chk("ldrise_pos",  32'(bus.Position), 5);
        chk("ldrise_idle", 32'(bus.Busy),     0);
        step();
        chk("ldrise_busy",   32'(bus.Busy),   1);
        chk("ldrise_guides", 32'(bus.Guides), 32'(GUIDE_G1));
        for (int i = 0; i < 2 * P; i++) step();
        chk("ldrise_commit_pos",   32'(bus.Position), 6);
        chk("ldrise_commit_busy",  32'(bus.Busy),     0);
        chk("ldrise_commit_carry", 32'(bus.Carry),    0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dekatron_step_seq.md
Name: dekatron_step_seq

Overview:
- Consumes the divided clock produced by the clock divider stage and sequences dekatron guide pulses.
- Each accepted rising edge of tick_in performs one dekatron step: a two-phase guide pulse sequence, then a position update.
- Tracks glow position 0..RADIX-1 and emits a carry/borrow pulse on wrap, for the next counter digit.
- Runs on the same system clock as the divider; tick_in is a synchronous level, edge-detected here.

Parameters:
- PHASE_CYCLES, 4, clock cycles each guide phase is held (>=1).
- RADIX, 10, dekatron cathode count; position wraps modulo RADIX.
- POS_W, 4, position width (>= clog2(RADIX)).

Ports:
- clock_in  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- tick_in  in  1  divided clock from divider stage (level, synchronous to clock_in).
- En  in  1  accept tick rising edges when 1.
- Dec  in  1  step direction: 0 = forward (+1), 1 = reverse (-1); sampled at step start.
- Load  in  1  load LoadValue into Position (IDLE only).
- LoadValue  in  POS_W  value to load.
- ClrOverrun  in  1  clears sticky Overrun.
- Guides  out  2  {G1,G2} guide drive, one-hot or 00.
- Position  out  POS_W  current glow cathode.
- Carry  out  1  one-cycle pulse on wrap (RADIX-1->0 forward, 0->RADIX-1 reverse).
- Busy  out  1  step in progress.
- Overrun  out  1  sticky: tick lost.

Behaviour:
- Interface: one clock (clock_in); reset Rst_n asynchronous, active-low. Reset forces all of the following to 0: Guides, Position, Carry, Busy, Overrun, pending flag, tick_q; state goes to IDLE.
- Edge detect: tick_q <= tick_in. rise = tick_in & ~tick_q & En. A held-high tick_in does not retrigger.
- States: IDLE, PH_A, PH_B. Phase counter sized clog2(PHASE_CYCLES)+1.
- IDLE + rise at edge N:
  - Latch Dec; PH_A occupies cycles N+1..N+P (P = PHASE_CYCLES).
  - Busy=1 from N+1.
- PH_A drive: forward Guides=2'b10 (G1); reverse Guides=2'b01 (G2).
- PH_B: cycles N+P+1..N+2P, drives the other guide.
- Last PH_B cycle commits the step; visible at cycle N+2P+1:
  - Position updates modulo RADIX.
  - Carry=1 for that cycle only on wrap.
  - With no pending tick: Guides=00, Busy=0, state IDLE.
  - With a pending tick: clear pending, latch current Dec, enter PH_A directly (Busy stays 1, no idle gap).
- Rise while Busy: set pending. Rise while pending already set: Overrun<=1; the tick is dropped.
- Overrun: cleared by ClrOverrun; if set and clear occur in the same cycle, set wins.
- Load:
  - Accepted only in IDLE.
  - LoadValue >= RADIX is ignored.
  - Load with rise in the same cycle: load wins, rise becomes pending, and the step starts next cycle from the loaded value.
  - Load while Busy is ignored.
- En deassert: clears pending; an in-progress step always completes.
- Reset mid-step: immediate return to reset values; no partial position update.

Decomposition:
- Package dekatron_pkg:
  - state enum {IDLE, PH_A, PH_B}.
  - Guide encodings GUIDE_NONE=2'b00, GUIDE_G1=2'b10, GUIDE_G2=2'b01.
  - Default RADIX constant.
- One sub-module, tick_edge_detect: registered rising-edge detector with enable, async active-low reset; reusable by other digit stages.

Test Plan:
- P=4. Reset, En=1, tick rise sampled at cycle 10 -> Guides=10 cycles 11-14, 01 cycles 15-18, Busy 11-18. At cycle 19: Position=1, Busy=0, Guides=00, Carry=0.
- Load 9 in IDLE, Dec=0, one tick -> Position=0 and a single-cycle Carry at commit.
- Load 0, Dec=1, one tick -> Guides 01 then 10, Position=9, Carry pulse.
- Rise at 10, second rise at 13 -> pending. At 19: Position=1, Guides=10, Busy stays 1. At 27: Position=2, Busy=0. A third rise at 15 sets Overrun=1, which holds until ClrOverrun; check set-wins collision.
- Rst_n low during PH_B (cycle 16) -> all outputs 0 asynchronously, Position=0. After release, tick_in already high does not start a step.
- En=0 with toggling tick_in -> no Busy, no Position change. Load with value 12 is ignored. Load and rise in the same cycle -> loaded value then one step.
